// File: rtl/fp16_pkg.sv
// Shared half-precision definitions: field widths, bias, FSM encoding and
// field-extract helpers used by the half<->integer conversion stages.
package fp16_pkg;

  localparam int BIAS   = 15;
  localparam int W_EXP  = 5;
  localparam int W_MAN  = 10;
  localparam int W_HALF = 1 + W_EXP + W_MAN;
  localparam int W_OUT  = 16;
  localparam int W_MAG  = 17;
  localparam int W_CNT  = 4;

  // Exponent at which the 11-bit significand, read as an integer, already
  // equals the value: 1.m * 2^(e-BIAS) = sig * 2^(e-(BIAS+W_MAN)).
  localparam int EXP_UNIT = BIAS + W_MAN;
  // Largest exponent whose values are all below 0.5 and so round to zero.
  localparam int EXP_ZERO_MAX = BIAS - 2;
  // Exponent whose values only fit a signed 16-bit integer as exactly -32768.
  localparam int EXP_EDGE = BIAS + W_OUT - 1;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    SHIFT,
    ROUND,
    OUT,
    ERR
  } state_t;

  function automatic logic fp16_sign(input logic [W_HALF-1:0] h);
    return h[W_HALF-1];
  endfunction

  function automatic logic [W_EXP-1:0] fp16_exp(input logic [W_HALF-1:0] h);
    return h[W_MAN +: W_EXP];
  endfunction

  function automatic logic [W_MAN-1:0] fp16_man(input logic [W_HALF-1:0] h);
    return h[W_MAN-1:0];
  endfunction

endpackage

// File: rtl/fp16_to_int_if.sv
// Request/result signals of the half-to-integer converter. The requester
// drives the operand and R_I; the converter returns dataOut with strobes.
interface fp16_to_int_if;
  import fp16_pkg::*;

  logic [W_HALF-1:0] dataIn;
  logic              R_I;
  logic [W_OUT-1:0]  dataOut;
  logic              R_O;
  logic              REG_ERROR;

  modport master (
    output dataIn,
    output R_I,
    input  dataOut,
    input  R_O,
    input  REG_ERROR
  );

  modport slave (
    input  dataIn,
    input  R_I,
    output dataOut,
    output R_O,
    output REG_ERROR
  );

endinterface

// File: rtl/fp16_round_ne.sv
// Round-to-nearest, ties-to-even on an integer magnitude, given the first
// discarded bit (guard) and the OR of every bit below it (sticky).
module fp16_round_ne
  import fp16_pkg::*;
(
  input  logic [W_MAG-1:0] mag,
  input  logic             guard,
  input  logic             sticky,
  output logic [W_MAG-1:0] mag_rnd
);

  logic inc;

  // Above the halfway point always rounds up; exactly halfway only when odd.
  assign inc     = guard & (sticky | mag[0]);
  assign mag_rnd = mag + W_MAG'(inc);

endmodule

// File: rtl/fp16_to_int.sv
// Multi-cycle IEEE754 half-precision to signed 16-bit integer converter.
// The significand is shifted one bit per cycle to its integer position,
// rounded to nearest-even, then negated for negative operands. Values that
// cannot be represented raise REG_ERROR together with R_O.
module fp16_to_int
  import fp16_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  fp16_to_int_if.slave bus
);

  state_t state, state_nxt;

  logic [W_HALF-1:0] operand;
  logic [W_MAG-1:0]  mag;
  logic [W_MAG-1:0]  mag_rnd;
  logic [W_CNT-1:0]  cnt;
  logic              shl;
  logic              guard;
  logic              sticky;
  logic              err_q;
  logic [W_OUT-1:0]  data_out_q;
  logic              r_o;
  logic              reg_error;

  logic              op_sign;
  logic [W_EXP-1:0]  op_exp;
  logic [W_MAN-1:0]  op_man;
  logic              dec_zero;
  logic              dec_err;
  logic              exp_above;
  logic [W_CNT-1:0]  shift_n;

  assign op_sign = fp16_sign(operand);
  assign op_exp  = fp16_exp(operand);
  assign op_man  = fp16_man(operand);

  // Zero, -0, subnormals and everything below 0.5 convert to 0.
  assign dec_zero  = (op_exp <= W_EXP'(EXP_ZERO_MAX));
  // Inf/NaN, and anything at or beyond 2^15 except exactly -32768.
  assign dec_err   = (op_exp == '1) ||
                     ((op_exp == W_EXP'(EXP_EDGE)) && !(op_sign && (op_man == '0)));
  assign exp_above = (op_exp > W_EXP'(EXP_UNIT));
  assign shift_n   = exp_above ? W_CNT'(op_exp - W_EXP'(EXP_UNIT))
                               : W_CNT'(W_EXP'(EXP_UNIT) - op_exp);

  fp16_round_ne u_round (
    .mag     (mag),
    .guard   (guard),
    .sticky  (sticky),
    .mag_rnd (mag_rnd)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is written with <= so every register samples
    // pre-edge values and the update order inside the block does not matter.
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and strobe decode. Zero and error operands also pass through
  // ROUND, so every result leaves from the same finalise cycle.
  always_comb begin
    // NOTE: defaults first, so no branch leaves a signal unassigned and no
    // latch is inferred.
    state_nxt = state;
    r_o       = 1'b0;
    reg_error = 1'b0;
    case (state)
      IDLE:    if (bus.R_I) state_nxt = DECODE;
      DECODE:  begin
        if (dec_err || dec_zero || (shift_n == '0)) state_nxt = ROUND;
        else                                        state_nxt = SHIFT;
      end
      SHIFT:   if (cnt == W_CNT'(1)) state_nxt = ROUND;
      ROUND:   state_nxt = err_q ? ERR : OUT;
      OUT:     begin
        r_o       = 1'b1;
        state_nxt = IDLE;
      end
      ERR:     begin
        r_o       = 1'b1;
        reg_error = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, bit-serial shifter and result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      operand    <= '0;
      mag        <= '0;
      cnt        <= '0;
      shl        <= 1'b0;
      guard      <= 1'b0;
      sticky     <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.R_I) operand <= bus.dataIn;
        DECODE: begin
          guard  <= 1'b0;
          sticky <= 1'b0;
          err_q  <= dec_err;
          shl    <= exp_above;
          cnt    <= shift_n;
          if (dec_err || dec_zero) mag <= '0;
          else                     mag <= W_MAG'({1'b1, op_man});
        end
        SHIFT: begin
          cnt <= cnt - W_CNT'(1);
          if (shl) begin
            mag <= {mag[W_MAG-2:0], 1'b0};
          end else begin
            mag    <= {1'b0, mag[W_MAG-1:1]};
            guard  <= mag[0];
            sticky <= sticky | guard;
          end
        end
        ROUND: begin
          if (err_q) data_out_q <= '0;
          else       data_out_q <= W_OUT'(op_sign ? (~mag_rnd + W_MAG'(1)) : mag_rnd);
        end
        default: ;
      endcase
    end
  end

  assign bus.dataOut   = data_out_q;
  assign bus.R_O       = r_o;
  assign bus.REG_ERROR = reg_error;

endmodule

// File: tb/tb_fp16_to_int.sv
// Bench for fp16_to_int: directed vectors with hand-computed results and
// latencies, plus an arithmetic reference model compared on every cycle.
module tb_fp16_to_int;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  fp16_to_int_if bus ();

  fp16_to_int dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference conversion from the number's value: integer part plus a
  // remainder compared against one half. Latency counts edges from the
  // capture edge to the edge after which R_O is high.
  function automatic void model_conv(input logic [15:0] h, output logic [15:0] val,
                                     output logic err, output int lat);
    int e, m, sig, mag, k, q, rem, half;
    bit s;
    s   = h[15];
    e   = int'(h[14:10]);
    m   = int'(h[9:0]);
    val = '0;
    err = 1'b0;
    lat = 2;
    if (e == 31 || (e == 30 && !(s && m == 0))) begin
      err = 1'b1;
      return;
    end
    if (e <= 13) return;
    sig = 1024 + m;
    if (e >= 25) begin
      mag = sig * (1 << (e - 25));
      lat = (e - 25) + 2;
    end else begin
      k    = 25 - e;
      q    = sig / (1 << k);
      rem  = sig - q * (1 << k);
      half = 1 << (k - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      mag = q;
      lat = k + 2;
    end
    if (s) mag = -mag;
    val = 16'(mag);
  endfunction

  // Reference model of the request/result protocol.
  logic        m_ro   = 1'b0;
  logic        m_err  = 1'b0;
  logic [15:0] m_dout = '0;
  logic [15:0] p_val  = '0;
  logic        p_err  = 1'b0;
  int          m_cnt  = 0;
  bit          m_busy = 1'b0;

  always @(posedge clk or negedge reset) begin : model
    logic [15:0] v;
    logic        e;
    int          l;
    if (!reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_ro   <= 1'b0;
      m_err  <= 1'b0;
      m_dout <= '0;
    end else if (m_ro) begin
      m_ro   <= 1'b0;
      m_err  <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_ro   <= 1'b1;
        m_err  <= p_err;
        m_dout <= p_val;
      end
      m_cnt <= m_cnt - 1;
    end else if (bus.R_I) begin
      model_conv(bus.dataIn, v, e, l);
      p_val  <= v;
      p_err  <= e;
      m_cnt  <= l;
      m_busy <= 1'b1;
    end
  end

  // Compare DUT outputs against the model mid-cycle, every cycle.
  always @(negedge clk) begin
    check("cmp_R_O", 32'(bus.R_O), 32'(m_ro));
    check("cmp_REG_ERROR", 32'(bus.REG_ERROR), 32'(m_err));
    check("cmp_dataOut", 32'(bus.dataOut), 32'(m_dout));
  end

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs [22] = '{
    '{16'h3C00, 16'h0001, 1'b0, 12},  // 1.0
    '{16'hC500, 16'hFFFB, 1'b0, 10},  // -5.0
    '{16'h3E00, 16'h0002, 1'b0, 12},  // 1.5 -> tie to even 2
    '{16'h4100, 16'h0002, 1'b0, 11},  // 2.5 -> tie to even 2
    '{16'h3800, 16'h0000, 1'b0, 13},  // 0.5 -> tie to even 0
    '{16'h77FF, 16'h7FF0, 1'b0, 6},   // 32752
    '{16'hF800, 16'h8000, 1'b0, 7},   // -32768
    '{16'h8000, 16'h0000, 1'b0, 2},   // -0
    '{16'h0001, 16'h0000, 1'b0, 2},   // subnormal
    '{16'h7800, 16'h0000, 1'b1, 2},   // 32768
    '{16'h7C00, 16'h0000, 1'b1, 2},   // +inf
    '{16'h7E00, 16'h0000, 1'b1, 2},   // NaN
    '{16'hF801, 16'h0000, 1'b1, 2},   // below -32768
    '{16'h6640, 16'h0640, 1'b0, 2},   // e=25, no shift
    '{16'h6800, 16'h0800, 1'b0, 3},   // e=26, one left shift
    '{16'h3A00, 16'h0001, 1'b0, 13},  // 0.75
    '{16'h3400, 16'h0000, 1'b0, 2},   // 0.25, e=13
    '{16'hBC00, 16'hFFFF, 1'b0, 12},  // -1.0
    '{16'h4300, 16'h0004, 1'b0, 11},  // 3.5 -> 4
    '{16'h4200, 16'h0003, 1'b0, 11},  // 3.0
    '{16'hF7FF, 16'h8010, 1'b0, 6},   // -32752
    '{16'hB800, 16'h0000, 1'b0, 13}   // -0.5 -> 0
  };

  // Waits (bounded) for R_O, sampling 1 time unit after each rising edge.
  task automatic wait_ro(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!bus.R_O && edges < 40);
  endtask

  task automatic run_vec(input vec_t v);
    int edges;
    @(negedge clk);
    bus.R_I    = 1'b1;
    bus.dataIn = v.din;
    @(posedge clk);
    #1;
    bus.R_I    = 1'b0;
    bus.dataIn = 16'h5A5A;
    wait_ro(edges);
    check($sformatf("lat_%04h", v.din), 32'(edges), 32'(v.lat));
    check($sformatf("dout_%04h", v.din), 32'(bus.dataOut), 32'(v.dout));
    check($sformatf("err_%04h", v.din), 32'(bus.REG_ERROR), 32'(v.err));
    @(posedge clk);
    #1;
    check($sformatf("ro_one_cycle_%04h", v.din), 32'(bus.R_O), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] pool [6];
    int edges;
    int seen;
    pool = '{16'h3C00, 16'hC500, 16'h7C00, 16'h0001, 16'h6640, 16'h3A00};

    bus.R_I    = 1'b0;
    bus.dataIn = '0;
    reset      = 1'b1;
    #2 reset   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_R_O", 32'(bus.R_O), 32'd0);
    check("rst_REG_ERROR", 32'(bus.REG_ERROR), 32'd0);
    check("rst_dataOut", 32'(bus.dataOut), 32'd0);
    #2 reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // R_I held high across two operands: second capture on the first IDLE
    // cycle after OUT, i.e. 13 edges after the first R_O for a 2.5 operand.
    @(negedge clk);
    bus.R_I    = 1'b1;
    bus.dataIn = 16'hC500;
    @(posedge clk);
    #1;
    bus.dataIn = 16'h4100;
    wait_ro(edges);
    check("b2b_lat1", 32'(edges), 32'd10);
    check("b2b_dout1", 32'(bus.dataOut), 32'h0000FFFB);
    wait_ro(edges);
    check("b2b_gap", 32'(edges), 32'd13);
    check("b2b_dout2", 32'(bus.dataOut), 32'h00000002);
    bus.R_I = 1'b0;
    @(posedge clk);

    // R_I and operand toggling freely, including while busy.
    repeat (80) begin
      @(negedge clk);
      bus.R_I    = 1'($urandom_range(0, 1));
      bus.dataIn = pool[$urandom_range(0, 5)];
    end
    @(negedge clk);
    bus.R_I = 1'b0;
    repeat (20) @(negedge clk);

    // Leave a nonzero result, then abort a conversion mid-SHIFT.
    run_vec('{16'h4300, 16'h0004, 1'b0, 11});
    @(negedge clk);
    bus.R_I    = 1'b1;
    bus.dataIn = 16'h3C00;
    @(posedge clk);
    #1;
    bus.R_I = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2;
    reset   = 1'b0;
    bus.R_I = 1'b1;
    #1;
    check("abort_R_O", 32'(bus.R_O), 32'd0);
    check("abort_REG_ERROR", 32'(bus.REG_ERROR), 32'd0);
    check("abort_dataOut", 32'(bus.dataOut), 32'd0);
    @(negedge clk);
    bus.R_I = 1'b0;
    #2 reset = 1'b1;
    seen = 0;
    repeat (16) begin
      @(posedge clk);
      #1;
      if (bus.R_O) seen++;
    end
    check("abort_no_R_O", 32'(seen), 32'd0);
    run_vec('{16'hC500, 16'hFFFB, 1'b0, 10});

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fp16_to_int.md
FP16_TO_INT -- requirements
Module: fp16_to_int

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; the ports are named clk and reset as elsewhere in the codebase.
REQ-002 SHALL expose: clk  input  1  rising-edge clock.
REQ-003 SHALL expose: reset  input  1  asynchronous active-low reset.
REQ-004 SHALL expose: dataIn  input  16  IEEE754 half-precision operand (sign[15], exponent[14:10], mantissa[9:0]).
REQ-005 SHALL expose: R_I  input  1  request; samples dataIn when high in IDLE.
REQ-006 SHALL expose: dataOut  output  16  two's-complement signed integer result.
REQ-007 SHALL expose: R_O  output  1  one-cycle result strobe.
REQ-008 SHALL expose: REG_ERROR  output  1  one-cycle error strobe, coincident with R_O.
REQ-009 SHALL use constants BIAS = 15, W_EXP = 5, W_MAN = 10.

Function
REQ-010 SHALL use states IDLE, DECODE, SHIFT, ROUND, OUT, ERR.
REQ-011 IDLE with R_I=1 SHALL capture dataIn and go to DECODE; R_I SHALL be ignored in every other state.
REQ-012 DECODE: exponent e=0 (zero, -0 or subnormal) or e<=13 SHALL load result 0 and go to OUT.
REQ-013 DECODE: e=31, e=30 with sign 0, or e=30 with sign 1 and mantissa!=0 SHALL go to ERR.
REQ-014 DECODE otherwise SHALL load sig={1,mantissa} (11 bits) into a 17-bit magnitude register and set shift count n=|e-25|; if n=0 go to ROUND, else go to SHIFT.
REQ-015 SHIFT SHALL shift exactly one bit per cycle and decrement n, leaving after n cycles: left if e>25; right if e<25, with guard = last bit shifted out and sticky = OR of all earlier shifted-out bits.
REQ-016 ROUND SHALL round to nearest, ties to even: increment if guard & (sticky | lsb); then negate if sign=1; go to OUT.
REQ-017 OUT SHALL drive R_O=1 and REG_ERROR=0 for exactly one cycle with dataOut valid, then go to IDLE.
REQ-018 ERR SHALL drive R_O=1 and REG_ERROR=1 for exactly one cycle with dataOut=0x0000, then go to IDLE.
REQ-019 Latency: R_O SHALL rise n+2 edges after the capture edge on the normal path, and 2 edges after it on zero/error paths.
REQ-020 dataOut SHALL hold its last value until the next OUT/ERR cycle.
REQ-021 Back-to-back: R_I held high SHALL be accepted again on the first IDLE cycle after OUT/ERR.

Reset
REQ-022 reset=0 SHALL immediately force state IDLE, dataOut=0, R_O=0, REG_ERROR=0, and clear all internal registers.
REQ-023 Reset mid-conversion SHALL abandon the operand with no R_O pulse; the first post-reset request SHALL convert normally.

Structure
REQ-024 Package fp16_pkg SHALL hold the state encoding, BIAS, W_EXP, W_MAN and the field-extract helpers, so they are shared with the integer-to-half stage.
REQ-025 Rounding SHALL be one combinational sub-module fp16_round_ne (magnitude, guard, sticky -> rounded magnitude); everything else SHALL be in fp16_to_int.

Verification
REQ-026 Drive 0x3C00 (1.0) -> dataOut 0x0001, R_O 12 edges after capture, REG_ERROR 0.
REQ-027 Drive 0xC500 (-5.0) -> 0xFFFB; drive 0x3E00 (1.5) -> 0x0002; drive 0x4100 (2.5) -> 0x0002; drive 0x3800 (0.5) -> 0x0000.
REQ-028 Drive 0x77FF -> 0x7FF0; drive 0xF800 -> 0x8000; drive 0x8000 and 0x0001 -> 0x0000 after 2 edges.
REQ-029 Drive 0x7800, 0x7C00, 0x7E00, 0xF801 -> R_O=1, REG_ERROR=1, dataOut 0x0000.
REQ-030 Hold R_I high across two operands, pulse reset low mid-SHIFT, and toggle R_I while busy -> no extra captures, no R_O during or after the aborted conversion, and the next conversion is correct.
